// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the block-transfer memory interface.
// Word i of a packed block occupies bits [i*width +: width].
package mem_if_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic int unsigned block_size(input int unsigned offset_width);
    return 32'd1 << offset_width;
  endfunction

  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  function automatic int unsigned word_index(input int unsigned bit_pos,
                                             input int unsigned width);
    return bit_pos / width;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-addressed RAM: one combinational-read/synchronous-write transfer port plus two
// registered read ports. Registered reads see the pre-write value on a same-cycle collision.
module word_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 10,
  parameter              InitFile  = ""
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [AddrWidth-1:0] xfer_addr,
  input  logic                 xfer_we,
  input  logic [DataWidth-1:0] xfer_wdata,
  output logic [DataWidth-1:0] xfer_rdata,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data,
  input  logic [AddrWidth-1:0] dbg_addr,
  output logic [DataWidth-1:0] dbg_data
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  // Elaboration-time contents: all words zero.
  initial begin
    for (int i = 0; i < Depth; i++) begin
      mem[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer_we) begin
      mem[xfer_addr] <= xfer_wdata;
    end
  end

  assign xfer_rdata = mem[xfer_addr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= '0;
      dbg_data <= '0;
    end else begin
      rd_data  <= mem[rd_addr];
      dbg_data <= mem[dbg_addr];
    end
  end

endmodule

// File: rtl/block_memory_responder.sv
// Slow main-memory model for a cache block interface: moves one word per cycle and
// pulses block_valid DELAY cycles after accepting a request.
module block_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH         = 10,
  parameter int unsigned BLOCK_OFFSET_WIDTH = 3,
  parameter int unsigned DELAY              = 16,
  parameter              INIT_FILE          = ""
) (
  input  logic                                                   clk,
  input  logic                                                   rstn,
  input  logic                                                   req,
  input  logic                                                   we,
  input  logic [ADDR_WIDTH-1:0]                                  addr,
  input  logic [DATA_WIDTH*block_size(BLOCK_OFFSET_WIDTH)-1:0]   block_din,
  output logic                                                   block_valid,
  output logic [DATA_WIDTH*block_size(BLOCK_OFFSET_WIDTH)-1:0]   block_dout,
  output logic [DATA_WIDTH-1:0]                                  dout,
  output logic                                                   dout_valid,
  input  logic [ADDR_WIDTH-1:0]                                  debug_addr,
  output logic [DATA_WIDTH-1:0]                                  debug_dout
);

  localparam int unsigned BlockSize = block_size(BLOCK_OFFSET_WIDTH);
  localparam int unsigned CntWidth  = $clog2(DELAY + 1);

  if (DELAY < BlockSize) begin : g_delay_check
    $error("block_memory_responder: DELAY must be >= BLOCK_SIZE");
  end

  state_e                                   state_q, state_d;
  logic [CntWidth-1:0]                      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                    base_q;
  logic                                     we_q;
  logic [BlockSize-1:0][DATA_WIDTH-1:0]     wblock_q;
  logic [BlockSize-1:0][DATA_WIDTH-1:0]     block_dout_q, block_dout_d;
  logic                                     block_valid_q, block_valid_d;
  logic                                     dout_valid_q;

  logic                                     accept;
  logic                                     xfer;
  logic [BLOCK_OFFSET_WIDTH-1:0]            word_idx;
  logic [ADDR_WIDTH-1:0]                    ram_addr;
  logic [DATA_WIDTH-1:0]                    ram_rdata;

  assign accept   = (state_q == StIdle) && req;
  assign xfer     = (state_q == StBusy) && (cnt_q < CntWidth'(BlockSize));
  assign word_idx = cnt_q[BLOCK_OFFSET_WIDTH-1:0];
  // base is block-aligned, so splicing in the word index never wraps.
  assign ram_addr = {base_q[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], word_idx};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    block_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntWidth'(DELAY - 1)) begin
          state_d       = StDone;
          block_valid_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    block_dout_d = block_dout_q;
    if (xfer && !we_q) begin
      block_dout_d[word_idx] = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      base_q        <= '0;
      we_q          <= 1'b0;
      wblock_q      <= '0;
      block_dout_q  <= '0;
      block_valid_q <= 1'b0;
      dout_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      block_dout_q  <= block_dout_d;
      block_valid_q <= block_valid_d;
      dout_valid_q  <= (state_q == StIdle) && !req;
      if (accept) begin
        base_q   <= {addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
        we_q     <= we;
        wblock_q <= block_din;
      end
    end
  end

  word_ram #(
    .DataWidth (DATA_WIDTH),
    .AddrWidth (ADDR_WIDTH),
    .InitFile  (INIT_FILE)
  ) u_word_ram (
    .clk        (clk),
    .rstn       (rstn),
    .xfer_addr  (ram_addr),
    .xfer_we    (xfer && we_q),
    .xfer_wdata (wblock_q[word_idx]),
    .xfer_rdata (ram_rdata),
    .rd_addr    (addr),
    .rd_data    (dout),
    .dbg_addr   (debug_addr),
    .dbg_data   (debug_dout)
  );

  assign block_valid = block_valid_q;
  assign block_dout  = block_dout_q;
  assign dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Self-checking bench for block_memory_responder against a flat-array memory model.
module tb_block_memory_responder;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int BOW = 3;
  localparam int BS  = 8;
  localparam int DLY = 16;
  localparam int BW  = DW * BS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [AW-1:0] debug_addr = '0;
  logic [BW-1:0] block_din = '0;
  logic          block_valid;
  logic [BW-1:0] block_dout;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [DW-1:0] debug_dout;

  block_memory_responder #(
    .DATA_WIDTH         (DW),
    .ADDR_WIDTH         (AW),
    .BLOCK_OFFSET_WIDTH (BOW),
    .DELAY              (DLY),
    .INIT_FILE          ("")
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .block_din   (block_din),
    .block_valid (block_valid),
    .block_dout  (block_dout),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .debug_addr  (debug_addr),
    .debug_dout  (debug_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [DW-1:0] model [1024];

  always @(negedge clk) if (block_valid === 1'b1) pulses++;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] seed;
    logic [DW-1:0] exp_w0;
    logic [DW-1:0] exp_w7;
  } vec_t;

  vec_t vecs[8];

  function automatic void check(input string name, input logic [BW-1:0] act,
                                input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [BW-1:0] make_block(input logic [DW-1:0] seed);
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = seed + DW'(i);
    return b;
  endfunction

  function automatic logic [BW-1:0] model_block(input int base);
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = model[base + i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_block_valid"}, BW'(block_valid), '0);
    check({tag, "_block_dout"}, block_dout, '0);
    check({tag, "_dout"}, BW'(dout), '0);
    check({tag, "_dout_valid"}, BW'(dout_valid), '0);
    check({tag, "_debug_dout"}, BW'(debug_dout), '0);
  endtask

  // Single transaction from IDLE; optionally disturbs the inputs 3 edges after acceptance.
  task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] blk,
                        input bit disturb, input string name, output logic [BW-1:0] got);
    int lat;
    int base;
    base = int'(a) & ~(BS - 1);
    lat = -1;
    got = '0;
    req = 1'b1; we = w; addr = a; block_din = blk;
    tick();
    for (int k = 1; k <= DLY + 8; k++) begin
      tick();
      if (disturb && k == 3) begin
        addr = 10'd40; we = ~w; block_din = ~blk;
      end
      if (block_valid) begin
        lat = k;
        got = block_dout;
        break;
      end
    end
    req = 1'b0;
    check({name, "_latency"}, BW'(lat), BW'(DLY));
    tick();
    check({name, "_pulse_width"}, BW'(block_valid), '0);
    if (w) begin
      for (int i = 0; i < BS; i++) model[base + i] = blk[i*DW +: DW];
    end else begin
      check({name, "_data"}, got, model_block(base));
    end
  endtask

  task automatic check_ports(input logic [AW-1:0] a, input logic [AW-1:0] d, input string name);
    addr = a; debug_addr = d; req = 1'b0;
    tick();
    check({name, "_dout"}, BW'(dout), BW'(model[a]));
    check({name, "_dout_valid"}, BW'(dout_valid), BW'(1));
    check({name, "_debug_dout"}, BW'(debug_dout), BW'(model[d]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] got;
    logic [BW-1:0] blk;
    int p1, p2, np, dv, pulses_before;

    for (int i = 0; i < 1024; i++) model[i] = '0;

    vecs[0] = '{1'b1, 10'd10,   32'h8,    32'h0,    32'h0};
    vecs[1] = '{1'b0, 10'd10,   32'h0,    32'h8,    32'hF};
    vecs[2] = '{1'b1, 10'd24,   32'hA0,   32'h0,    32'h0};
    vecs[3] = '{1'b0, 10'd24,   32'h0,    32'hA0,   32'hA7};
    vecs[4] = '{1'b0, 10'd1023, 32'h0,    32'h0,    32'h0};
    vecs[5] = '{1'b1, 10'd1016, 32'h300,  32'h0,    32'h0};
    vecs[6] = '{1'b1, 10'd19,   32'h1000, 32'h0,    32'h0};
    vecs[7] = '{1'b0, 10'd17,   32'h0,    32'h1000, 32'h1007};

    // Reset state
    tick(); tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Table-driven transactions
    foreach (vecs[v]) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      do_txn(vecs[v].w, vecs[v].a, make_block(vecs[v].seed), 1'b0, nm, got);
      if (!vecs[v].w) begin
        check({nm, "_w0"}, BW'(got[DW-1:0]), BW'(vecs[v].exp_w0));
        check({nm, "_w7"}, BW'(got[7*DW +: DW]), BW'(vecs[v].exp_w7));
      end
    end
    check_ports(10'd10, 10'd27, "idle_ports");
    check("debug_27_const", BW'(debug_dout), BW'(32'hA3));

    // Input stability: inputs change mid-read of block 0
    do_txn(1'b1, 10'd0, make_block(32'h5000), 1'b0, "pre_b0", got);
    do_txn(1'b1, 10'd40, make_block(32'h6000), 1'b0, "pre_b40", got);
    do_txn(1'b0, 10'd0, make_block(32'hDEAD0), 1'b1, "stable_rd0", got);
    do_txn(1'b0, 10'd40, '0, 1'b0, "stable_rd40", got);
    do_txn(1'b0, 10'd0, '0, 1'b0, "stable_rd0_again", got);

    // Held request across two transactions: write then read of block 48
    blk = make_block(32'h7700);
    req = 1'b1; we = 1'b1; addr = 10'd48; block_din = blk;
    p1 = -1; p2 = -1; np = 0; dv = 0; got = '0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (dout_valid) dv++;
      if (block_valid) begin
        if (np == 0) p1 = e; else p2 = e;
        np++;
        if (np == 1) we = 1'b0;
        if (np == 2) begin
          got = block_dout;
          break;
        end
      end
    end
    req = 1'b0;
    tick();
    for (int i = 0; i < BS; i++) model[48 + i] = blk[i*DW +: DW];
    check("held_pulses", BW'(np), BW'(2));
    check("held_first_latency", BW'(p1), BW'(DLY));
    check("held_spacing", BW'(p2 - p1), BW'(DLY + 2));
    check("held_dout_valid_high", BW'(dv), '0);
    check("held_read_data", got, model_block(48));

    // Reset mid-write of block 16: four words land before reset
    pulses_before = pulses;
    req = 1'b1; we = 1'b1; addr = 10'd16; block_din = {BS{32'h55}};
    tick();
    for (int k = 1; k <= 4; k++) tick();
    req = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst_async");
    tick(); tick();
    check_reset_outputs("midrst_held");
    rstn = 1'b1;
    for (int i = 16; i < 20; i++) model[i] = 32'h55;
    for (int k = 0; k < DLY + 8; k++) tick();
    check("midrst_no_pulse", BW'(pulses), BW'(pulses_before));
    for (int i = 16; i < 24; i++) check_ports(AW'(i), AW'(i), $sformatf("midrst_mem%0d", i));

    // Top block write with a debug read colliding on word 0
    req = 1'b1; we = 1'b1; addr = 10'd1023; block_din = make_block(32'h700);
    debug_addr = 10'd1016;
    tick();
    tick();
    check("collide_old", BW'(debug_dout), BW'(32'h300));
    tick();
    check("collide_new", BW'(debug_dout), BW'(32'h700));
    np = 0;
    for (int k = 0; k < DLY + 8; k++) begin
      tick();
      if (block_valid) begin
        np = 1;
        break;
      end
    end
    req = 1'b0;
    check("collide_done", BW'(np), BW'(1));
    tick();
    for (int i = 0; i < BS; i++) model[1016 + i] = 32'h700 + DW'(i);
    for (int i = 0; i < BS; i++) begin
      check_ports(AW'(1016 + i), AW'(i), $sformatf("top_nowrap%0d", i));
    end

    // Randomised transactions against the model
    for (int n = 0; n < 30; n++) begin
      logic          rw;
      logic [AW-1:0] ra;
      rw = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 1023));
      for (int i = 0; i < BS; i++) blk[i*DW +: DW] = $urandom;
      do_txn(rw, ra, blk, 1'b0, $sformatf("rand%0d", n), got);
      if (n % 3 == 0) begin
        check_ports(AW'($urandom_range(0, 1023)), ra, $sformatf("rand_ports%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
